// File: rtl/serial_adder_sub.sv
// serial_adder_sub: multi-cycle add/sub, BITS_PER_CYCLE bits per clock, LSB first.
// Ports: clk, rst_n (sync, active low), start/sub/a/b/cin in; busy/done/sum/cout out.
// Optional: define SERIAL_ADD_SUB_OVF_EN to add the ovf (signed overflow) output.

module fa_slice (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_sub #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int BPC = BITS_PER_CYCLE;
  localparam int N   = WIDTH / BPC;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 1 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_bad_cfg
    $error("serial_adder_sub: WIDTH must be a positive multiple of BITS_PER_CYCLE");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sh_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;
  logic [BPC:0]     c;
  logic [BPC-1:0]   r;

  assign last = (cnt == CW'(N - 1));
  assign busy = (state == RUN);
  assign done = (state == DONE);

  assign c[0] = carry;

  for (genvar gi = 0; gi < BPC; gi++) begin : g_chain
    fa_slice u_fa (
      .a  (a_sh[gi]),
      .b  (b_sh[gi]),
      .ci (c[gi]),
      .s  (r[gi]),
      .co (c[gi+1])
    );
  end

  // acc holds the slices already produced; the current slice
  // lands on top, so sh_nxt on the last edge is the full result.
  if (N > 1) begin : g_acc
    logic [WIDTH-BPC-1:0] acc;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        acc <= '0;
      end else if (state == RUN) begin
        acc <= sh_nxt[WIDTH-1:BPC];
      end
    end

    assign sh_nxt = {r, acc};
  end else begin : g_noacc
    assign sh_nxt = r;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            // subtract as a + ~b + 1
            b_sh  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> BPC;
          b_sh  <= b_sh >> BPC;
          carry <= c[BPC];
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum  <= sh_nxt;
            cout <= c[BPC];
`ifdef SERIAL_ADD_SUB_OVF_EN
            ovf  <= c[BPC] ^ c[BPC-1];
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_sub.sv
// tb_serial_adder_sub: directed scoreboard bench for serial_adder_sub.
// Drives an 8-bit/1bpc and a 16-bit/4bpc instance from one sequence.

module tb_serial_adder_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  logic        st8, sub8, cin8;
  logic [7:0]  a8, b8, sum8;
  logic        busy8, done8, cout8;

  logic        st16, sub16, cin16;
  logic [15:0] a16, b16, sum16;
  logic        busy16, done16, cout16;

`ifdef SERIAL_ADD_SUB_OVF_EN
  logic        ovf8, ovf16;
`endif

  serial_adder_sub #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (st8),
    .sub   (sub8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
`ifdef SERIAL_ADD_SUB_OVF_EN
    ,
    .ovf   (ovf8)
`endif
  );

  serial_adder_sub #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (st16),
    .sub   (sub16),
    .a     (a16),
    .b     (b16),
    .cin   (cin16),
    .busy  (busy16),
    .done  (done16),
    .sum   (sum16),
    .cout  (cout16)
`ifdef SERIAL_ADD_SUB_OVF_EN
    ,
    .ovf   (ovf16)
`endif
  );

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t model(input int w, input bit s,
                                 input logic [15:0] a,
                                 input logic [15:0] b,
                                 input bit ci);
    logic [16:0] mask, bb, full;
    exp_t e;
    mask   = (17'h1 << w) - 17'h1;
    bb     = (s ? {1'b0, ~b} : {1'b0, b}) & mask;
    full   = {1'b0, a} + bb + {16'h0, (s ? 1'b1 : ci)};
    e.sum  = full[15:0] & mask[15:0];
    e.cout = full[w];
    e.ovf  = (a[w-1] == bb[w-1]) && (full[w-1] != a[w-1]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit w16, input bit st, input bit s,
                       input logic [15:0] a, input logic [15:0] b,
                       input bit ci);
    if (w16) begin
      st16 = st; sub16 = s; a16 = a; b16 = b; cin16 = ci;
    end else begin
      st8 = st; sub8 = s; a8 = a[7:0]; b8 = b[7:0]; cin8 = ci;
    end
  endtask

  // Called on a negedge; returns on a negedge with start low.
  task automatic go(input bit w16, input bit s, input logic [15:0] a,
                    input logic [15:0] b, input bit ci,
                    input string tag, input bit hold);
    int   n, lat, bcnt, dcnt;
    exp_t e;
    logic bsy, dn;
    n    = w16 ? 4 : 8;
    lat  = -1;
    bcnt = 0;
    dcnt = 0;
    sb.push_back(model(w16 ? 16 : 8, s, a, b, ci));
    drive(w16, 1'b1, s, a, b, ci);
    @(negedge clk);
    drive(w16, hold, s, 16'($urandom), 16'($urandom), 1'($urandom));
    for (int j = 0; j < n + 4; j++) begin
      bsy = w16 ? busy16 : busy8;
      dn  = w16 ? done16 : done8;
      if (bsy) bcnt++;
      if (dn) begin
        dcnt++;
        if (lat < 0) begin
          lat = j;
          e = sb.pop_front();
          chk({tag, " sum"}, w16 ? {16'h0, sum16} : {24'h0, sum8},
              {16'h0, e.sum});
          chk({tag, " cout"}, w16 ? cout16 : cout8, e.cout);
`ifdef SERIAL_ADD_SUB_OVF_EN
          chk({tag, " ovf"}, w16 ? ovf16 : ovf8, e.ovf);
`endif
        end
      end
      if (hold && lat >= 0 && j == lat + 1) begin
        if (w16) st16 = 1'b0; else st8 = 1'b0;
      end
      @(negedge clk);
    end
    if (w16) st16 = 1'b0; else st8 = 1'b0;
    if (lat < 0) void'(sb.pop_front());
    chk({tag, " latency"}, lat, n);
    chk({tag, " busy cycles"}, bcnt, n);
    chk({tag, " done pulses"}, dcnt, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst busy8", busy8, 1'b0);
    chk("rst done8", done8, 1'b0);
    chk("rst sum8", sum8, 8'h00);
    chk("rst cout8", cout8, 1'b0);
    chk("rst busy16", busy16, 1'b0);
    chk("rst sum16", sum16, 16'h0000);
`ifdef SERIAL_ADD_SUB_OVF_EN
    chk("rst ovf8", ovf8, 1'b0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    go(1'b0, 1'b0, 16'h5A, 16'h3C, 1'b0, "add 5a+3c", 1'b0);
    go(1'b0, 1'b0, 16'hFF, 16'h01, 1'b0, "add ff+01", 1'b0);
    go(1'b0, 1'b0, 16'hFF, 16'h01, 1'b1, "add ff+01+1", 1'b0);
    go(1'b0, 1'b1, 16'h10, 16'h20, 1'b0, "sub 10-20", 1'b0);
    go(1'b0, 1'b1, 16'h80, 16'h01, 1'b1, "sub 80-01", 1'b0);
    go(1'b1, 1'b0, 16'h1234, 16'hEDCC, 1'b0, "w16 add", 1'b0);
    go(1'b1, 1'b1, 16'h8000, 16'h0001, 1'b0, "w16 sub", 1'b0);
    go(1'b1, 1'b0, 16'h7FFF, 16'h0000, 1'b1, "w16 add cin", 1'b0);
    go(1'b0, 1'b0, 16'hC3, 16'h3D, 1'b1, "held start", 1'b1);
    go(1'b0, 1'b0, 16'h21, 16'h13, 1'b0, "after held", 1'b0);

    // abort an 8-bit op with reset in its third RUN cycle
    drive(1'b0, 1'b1, 1'b0, 16'h5A, 16'h3C, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort busy", busy8, 1'b0);
    chk("abort done", done8, 1'b0);
    chk("abort sum", sum8, 8'h00);
    chk("abort cout", cout8, 1'b0);
    dcnt = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (done8 || busy8) dcnt++;
    end
    chk("abort no activity", dcnt, 0);

    go(1'b0, 1'b1, 16'h00, 16'h01, 1'b0, "post-reset sub", 1'b0);

    chk("scoreboard empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_sub.md
Name: serial_adder_sub

Overview:
- Parametrised multi-cycle adder/subtractor built around the team's gate-level full-adder slice.
- Processes BITS_PER_CYCLE bits per clock, LSB first, and keeps the running carry in a flip-flop.
- A start/busy/done handshake frames each operation.
- Used wherever a wide add/sub is needed at low area in place of a full-width ripple adder.

Parameters:
- WIDTH, 8: operand and result width in bits; must be ≥ 1.
- BITS_PER_CYCLE, 1: bits processed per clock; WIDTH must be divisible by it (elaboration error otherwise).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only in IDLE
- sub  input  1  0 = a+b+cin, 1 = a-b (two's complement)
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in for add; ignored when sub=1
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  result, held until next accepted start
- cout  output  1  final carry out; for sub, 1 = no borrow

Behaviour:
- Reset applies on a rising clk edge while rst_n=0:
  - state=IDLE, busy=0, done=0, sum=0, cout=0, carry FF=0, slice counter=0.
  - Reset mid-operation aborts the operation: no done pulse, and the partial result is discarded (sum=0).
- States are IDLE, RUN, DONE. N = WIDTH/BITS_PER_CYCLE.
- IDLE:
  - start=1 at edge k captures a, b, sub.
  - B register gets b when sub=0, ~b when sub=1.
  - Carry FF gets cin when sub=0, 1 when sub=1.
  - Counter gets 0, busy goes to 1, and the next state is RUN.
  - start=0 holds IDLE.
- RUN:
  - Each edge adds the low BITS_PER_CYCLE bits of the A/B shift registers plus the carry FF through a ripple chain of full-adder slices.
  - The slice result is shifted into sum from the MSB side, A/B shift right by BITS_PER_CYCLE, the carry FF takes the chain carry-out, and the counter increments.
  - On the edge that processes slice N-1 (edge k+N): next state DONE, busy goes to 0, done goes to 1, cout takes the final carry, and sum holds the complete result.
- Latency: done is high in the cycle following edge k+N. Total N+1 cycles from start to return to IDLE.
- DONE: lasts exactly one cycle, with done=1 and busy=0, then returns to IDLE. start in DONE is ignored.
- start while busy=1 or in DONE is ignored. Operand inputs are don't-care outside the accepting edge.
- Arithmetic is modulo 2^WIDTH; sum never extends beyond WIDTH.
- WIDTH=BITS_PER_CYCLE (N=1) is legal: single RUN cycle.
- sum is not modified during RUN as seen externally: shifting happens in an internal register that is copied to sum on the final edge.

Optional Feature:
- Macro: SERIAL_ADD_SUB_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit), which reports two's-complement signed overflow = carry into MSB XOR carry out of MSB.
  - ovf is registered alongside cout on the final RUN edge and held until the next accepted start.
  - ovf resets to 0.
- When undefined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, BPC=1; start, sub=0, a=0x5A, b=0x3C, cin=0 -> done exactly 8 cycles after the start edge; sum=0x96, cout=0, ovf=1; busy high for 8 cycles.
- sub=0, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Repeat with cin=1 -> sum=0x01, cout=1.
- sub=1, a=0x10, b=0x20 -> sum=0xF0, cout=0 (borrow), ovf=0. Then sub=1, a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
- WIDTH=16, BPC=4; a=0x1234, b=0xEDCC, sub=0 -> done 4 cycles after start; sum=0x0000, cout=1.
- start re-asserted every cycle during RUN and DONE -> only the first start is accepted; a single done pulse; next operation begins only from IDLE.
- rst_n=0 for one edge at RUN cycle 3 -> busy=0, done never pulses, sum=0, cout=0; a new start afterwards completes normally.
